// File: rtl/vco_adc_sample_fifo.sv
// Sample FIFO between the VCO ADC sinc decimator and the host-side reader.
// One write per data_valid_in strobe and one read per rd_en_in request.
// Read data is registered, so each accepted read returns its entry one cycle later.
// Also reports occupancy, a sticky overflow flag and a threshold interrupt.
// DEPTH must be a power of two (minimum 2), and ADDR_WIDTH must equal log2(DEPTH).
module vco_adc_sample_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  clear_in,
  input  logic                  rd_en_in,
  input  logic [ADDR_WIDTH:0]   threshold_in,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  output logic [ADDR_WIDTH:0]   count_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  overflow_out,
  output logic                  irq_out
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  drop;
  logic                  at_full;
  logic                  irq_next;

  // Accept/drop decisions and next-state occupancy.
  // Flags follow count_next, so they stay consistent with count_out.
  always_comb begin
    at_full    = (count_out == FULL_COUNT);
    rd_accept  = rd_en_in && (count_out != '0);
    // When full, a same-cycle accepted read frees the slot the write takes.
    wr_accept  = data_valid_in && (!at_full || rd_accept);
    drop       = data_valid_in && at_full && !rd_accept;
    count_next = count_out;
    if (clear_in) begin
      count_next = '0;
    end else if (wr_accept && !rd_accept) begin
      count_next = count_out + 1'b1;
    end else if (rd_accept && !wr_accept) begin
      count_next = count_out - 1'b1;
    end
    irq_next = (threshold_in != '0) && (count_next >= threshold_in);
  end

  // Sample storage.
  // It is not reset, and a clear discards the same-cycle write.
  always_ff @(posedge clk) begin
    if (wr_accept && !clear_in) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, read port, occupancy and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_out    <= '0;
      empty_out    <= 1'b1;
      full_out     <= 1'b0;
      overflow_out <= 1'b0;
      rd_data_out  <= '0;
      rd_valid_out <= 1'b0;
      irq_out      <= 1'b0;
    end else begin
      count_out <= count_next;
      empty_out <= (count_next == '0);
      full_out  <= (count_next == FULL_COUNT);
      irq_out   <= irq_next;
      if (clear_in) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        overflow_out <= 1'b0;
        rd_valid_out <= 1'b0;
      end else begin
        rd_valid_out <= rd_accept;
        if (wr_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_accept) begin
          rd_data_out <= mem[rd_ptr];
          rd_ptr      <= rd_ptr + 1'b1;
        end
        if (drop) begin
          overflow_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vco_adc_sample_fifo.sv
// Directed plus randomized bench for vco_adc_sample_fifo.
// Checks every output each cycle against a queue-based reference model.
module tb_vco_adc_sample_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_valid_in;
  logic          clear_in;
  logic          rd_en_in;
  logic [AW:0]   threshold_in;
  logic [DW-1:0] rd_data_out;
  logic          rd_valid_out;
  logic [AW:0]   count_out;
  logic          empty_out;
  logic          full_out;
  logic          overflow_out;
  logic          irq_out;

  vco_adc_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid_in(data_valid_in),
    .clear_in(clear_in), .rd_en_in(rd_en_in), .threshold_in(threshold_in),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .count_out(count_out),
    .empty_out(empty_out), .full_out(full_out), .overflow_out(overflow_out),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_ovf;
  int            n_asserts = 0;
  int            n_fails   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    int n;
    logic exp_irq;
    n = q.size();
    exp_irq = (threshold_in != 0) && (n >= int'(threshold_in));
    chk("rd_valid", DW'(rd_valid_out), DW'(exp_valid));
    chk("rd_data", rd_data_out, exp_data);
    chk("count", DW'(count_out), DW'(n));
    chk("empty", DW'(empty_out), DW'(n == 0));
    chk("full", DW'(full_out), DW'(n == DEPTH));
    chk("overflow", DW'(overflow_out), DW'(exp_ovf));
    chk("irq", DW'(irq_out), DW'(exp_irq));
  endtask

  task automatic model_reset();
    q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, then check all outputs.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    logic rd_ok, wr_ok;
    data_valid_in = v;
    data_in       = d;
    rd_en_in      = r;
    clear_in      = c;
    @(posedge clk);
    if (c) begin
      q.delete();
      exp_ovf   = 1'b0;
      exp_valid = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = v && ((q.size() < DEPTH) || rd_ok);
      exp_valid = rd_ok;
      if (rd_ok) exp_data = q.pop_front();
      if (wr_ok) q.push_back(d);
      else if (v) exp_ovf = 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] d;
    rst = 1'b0;
    data_in = '0; data_valid_in = 1'b0; clear_in = 1'b0; rd_en_in = 1'b0;
    threshold_in = '0;
    model_reset();
    #23;
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;

    // Three writes then three reads
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h33, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // Fill, drop one, drain
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, 0);
    step(1, 32'hDEAD, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Full with simultaneous write and read
    step(0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, DW'(100 + i), 0, 0);
    step(1, 32'hBEEF, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);

    // Empty with simultaneous write and read: no fall-through
    step(1, 32'h5, 1, 0);
    step(0, '0, 1, 0);

    // Continuous streaming across several pointer wraps
    step(1, $urandom, 0, 0);
    for (int i = 1; i < 40; i++) begin
      step(1, $urandom, 1, 0);
      chk("stream_count_le1", DW'(count_out <= 1), DW'(1));
    end
    step(0, '0, 1, 0);

    // Threshold irq, then clear with overflow set and count 3
    for (int i = 0; i < DEPTH + 1; i++) step(1, $urandom, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
    threshold_in = 5'd4;
    for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    // Randomized traffic with varying thresholds, including 0 and values beyond DEPTH
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) threshold_in = 5'($urandom_range(0, 20));
      d = $urandom;
      step(($urandom_range(0, 99) < 60), d, ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 3));
    end

    // Asynchronous reset in mid-sequence, between clock edges
    for (int i = 0; i < 6; i++) step(1, $urandom, (i > 3), 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
    threshold_in = 5'd1;
    step(1, 32'hCAFE, 0, 0);
    step(0, '0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
